pwm_capture_decoder: RTL and testbench

//   Receive-side counterpart of the CORDIC PWM PMOD generator: samples the

---
 rtl/pwm_capture_decoder.sv | 127 ++++++++++++
 tb/tb_pwm_capture_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture_decoder.sv
// Measures high time and period of each frame on an asynchronous PWM line.
// Emits one strobed sample per frame and flags a dead or stuck line as a sticky timeout.
module pwm_capture_decoder #(
    parameter int width       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [width-1:0] high_cnt,
    output logic [width-1:0] period_cnt,
    output logic             sample_valid,
    output logic             timeout,
    output logic             line_level,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    localparam logic [width-1:0] CNT_MAX = '1;
    localparam logic [width-1:0] CNT_ONE = {{(width-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q, s_d_d;
    state_t                 state_q, state_d;
    logic [width-1:0]       p_q, p_d;
    logic [width-1:0]       h_q, h_d;
    logic [width-1:0]       high_q, high_d;
    logic [width-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;
    logic                   s;
    logic                   rise;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], pwm_in};
        s_d_d     = s;
        state_d   = state_q;
        p_d       = p_q;
        h_d       = h_q;
        high_d    = high_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                // The frame in progress at reset is partial, so only arm here.
                if (rise) begin
                    p_d     = CNT_ONE;
                    h_d     = CNT_ONE;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d = p_q;
                    high_d   = h_q;
                    valid_d  = 1'b1;
                    p_d      = CNT_ONE;
                    h_d      = CNT_ONE;
                end else if (p_q == CNT_MAX) begin
                    period_d  = CNT_MAX;
                    high_d    = h_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = TIMEOUT;
                end else begin
                    p_d = p_q + CNT_ONE;
                    if (s) begin
                        h_d = h_q + CNT_ONE;
                    end
                end
            end
            TIMEOUT: begin
                // Restart silently; the dead stretch is not a valid frame.
                if (rise) begin
                    timeout_d = 1'b0;
                    p_d       = CNT_ONE;
                    h_d       = CNT_ONE;
                    state_d   = MEASURE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            s_d_q     <= 1'b0;
            state_q   <= IDLE;
            p_q       <= '0;
            h_q       <= '0;
            high_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            s_d_q     <= s_d_d;
            state_q   <= state_d;
            p_q       <= p_d;
            h_q       <= h_d;
            high_q    <= high_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign high_cnt     = high_q;
    assign period_cnt   = period_q;
    assign sample_valid = valid_q;
    assign timeout      = timeout_q;
    assign line_level   = s;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_pwm_capture_decoder.sv
// Bench for pwm_capture_decoder: directed frames plus random traffic, with samples
// predicted from the pin-level waveform and matched by a strobe-driven monitor.
module tb_pwm_capture_decoder;

    localparam int W   = 13;
    localparam int MAX = (1 << W) - 1;

    logic         clk1 = 1'b0;
    logic         reset;
    logic         pwm_in;
    logic [W-1:0] high_cnt;
    logic [W-1:0] period_cnt;
    logic         sample_valid;
    logic         timeout;
    logic         line_level;
    logic [1:0]   fsm_state;

    pwm_capture_decoder #(.width(W), .SYNC_STAGES(2)) dut (
        .clk1        (clk1),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .high_cnt    (high_cnt),
        .period_cnt  (period_cnt),
        .sample_valid(sample_valid),
        .timeout     (timeout),
        .line_level  (line_level),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk1 = ~clk1;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [2*W:0] exp_q[$];
    logic [2*W:0] mon_exp;

    // Reference: a sample is the span between two pin rises, high time is the
    // number of high pin cycles inside that span; a span reaching MAX is a timeout.
    int idx       = 0;
    int last_rise = 0;
    int ones      = 0;
    bit prev_bit  = 1'b0;
    bit armed     = 1'b0;
    bit dead      = 1'b0;

    task automatic model_reset();
        prev_bit = 1'b0;
        armed    = 1'b0;
        dead     = 1'b0;
        ones     = 0;
    endtask

    task automatic model_step(input bit b);
        logic [W-1:0] hv;
        logic [W-1:0] pv;
        if (b && !prev_bit) begin
            if (armed && !dead) begin
                hv = W'(ones);
                pv = W'(idx - last_rise);
                exp_q.push_back({1'b0, hv, pv});
            end
            armed     = 1'b1;
            dead      = 1'b0;
            last_rise = idx;
            ones      = 0;
        end else if (armed && !dead && (idx - last_rise) == MAX) begin
            hv = W'(ones);
            pv = W'(MAX);
            exp_q.push_back({1'b1, hv, pv});
            dead = 1'b1;
        end
        if (b) ones++;
        prev_bit = b;
        idx++;
    endtask

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, req);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk1) begin
        if (reset && sample_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_strobe: got high=%0d period=%0d timeout=%0b, required no strobe",
                         high_cnt, period_cnt, timeout);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({timeout, high_cnt, period_cnt} == mon_exp) n_pass++;
                else $display("FAIL sample: got high=%0d period=%0d timeout=%0b, required high=%0d period=%0d timeout=%0b",
                              high_cnt, period_cnt, timeout,
                              mon_exp[2*W-1:W], mon_exp[W-1:0], mon_exp[2*W]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input bit b);
        @(negedge clk1);
        pwm_in = b;
        model_step(b);
    endtask

    task automatic drive_frame(input int h, input int p);
        for (int i = 0; i < p; i++) drive_bit(i < h);
    endtask

    task automatic drive_const(input bit b, input int n);
        for (int i = 0; i < n; i++) drive_bit(b);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_high"},   int'(high_cnt),     0);
        check({tag, "_period"}, int'(period_cnt),   0);
        check({tag, "_valid"},  int'(sample_valid), 0);
        check({tag, "_tmo"},    int'(timeout),      0);
        check({tag, "_level"},  int'(line_level),   0);
        check({tag, "_state"},  int'(fsm_state),    0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p;
        int h;
        int total;
        int len;
        bit v;
        reset  = 1'b0;
        pwm_in = 1'b0;
        #100;
        check_idle_outputs("reset");
        @(negedge clk1);
        reset = 1'b1;
        model_reset();

        // 25% duty, first frame discarded
        for (int i = 0; i < 4; i++) drive_frame(1024, 4096);

        // duty sweep, then a dead low line
        drive_frame(1, 4096);
        drive_frame(2048, 4096);
        drive_frame(4095, 4096);
        drive_frame(4095, 4096);
        drive_const(1'b0, MAX);
        check("low_timeout_flag",  int'(timeout),   1);
        check("low_timeout_state", int'(fsm_state), 2);

        // restart without a sample, then stuck high
        drive_frame(1024, 4096);
        check("restart_tmo_clear", int'(timeout),   0);
        check("restart_state",     int'(fsm_state), 1);
        drive_const(1'b1, MAX + 100);
        check("high_timeout_flag", int'(timeout),    1);
        check("high_line_level",   int'(line_level), 1);
        drive_const(1'b0, 100);
        drive_frame(1024, 4096);
        check("restart2_tmo_clear", int'(timeout), 0);

        // minimum frame P=2, H=1
        for (int i = 0; i < 10; i++) drive_frame(1, 2);
        drive_const(1'b0, 4);

        // asynchronous reset mid-frame
        for (int i = 0; i < 500; i++) drive_bit(i < 1024);
        @(posedge clk1);
        #3;
        reset = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        pwm_in = 1'b0;
        model_reset();
        repeat (5) @(negedge clk1);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) drive_frame(1024, 4096);

        // random frames
        for (int i = 0; i < 20; i++) begin
            p = $urandom_range(2, 300);
            h = $urandom_range(1, p - 1);
            drive_frame(h, p);
        end

        // random run-length noise
        total = 0;
        while (total < 1000) begin
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 20);
            drive_const(v, len);
            total += len;
        end
        drive_const(1'b0, 20);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
